seq_shiftadd_mult: RTL

SEQ_SHIFTADD_MULT -- requirements
Module: seq_shiftadd_mult

---
 rtl/seq_mult_pkg.sv | 12 +
 rtl/seq_mult_ctrl.sv | 81 ++++++++
 rtl/seq_shiftadd_mult.sv | 105 ++++++++++
 3 files changed

// File: rtl/seq_mult_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
package seq_mult_pkg;

   localparam int SEQ_MULT_W_DEFAULT = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/seq_mult_ctrl.sv
// Controller for the shift-add multiplier: FSM, iteration counter, load/step/finish strobes.
// SEQ_MULT_EARLY_EXIT_EN ends RUN once the remaining multiplier bits are all zero.
module seq_mult_ctrl
   import seq_mult_pkg::*;
#(
   parameter int W = SEQ_MULT_W_DEFAULT
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid_i,
   input  logic                   out_ready_i,
   input  logic                   mplier_zero_i,
   output state_e                 state_o,
   output logic [$clog2(W+1)-1:0] cnt_o,
   output logic                   load_o,
   output logic                   step_o,
   output logic                   finish_o,
   output logic                   in_ready_o,
   output logic                   out_valid_o,
   output logic                   busy_o
);

   localparam int CW = $clog2(W+1);

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            last_step;

`ifdef SEQ_MULT_EARLY_EXIT_EN
   // mplier_zero_i looks at the multiplier after this step's shift
   assign last_step = (cnt_q == CW'(W-1)) || mplier_zero_i;
`else
   logic unused_mplier_zero;
   assign unused_mplier_zero = mplier_zero_i;
   assign last_step = (cnt_q == CW'(W-1));
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (in_valid_i) begin
               state_d = RUN;
               cnt_d   = '0;
            end
         end
         RUN: begin
            cnt_d = cnt_q + CW'(1);
            if (last_step) state_d = DONE;
         end
         DONE: begin
            if (out_ready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      load_o      = (state_q == IDLE) && in_valid_i;
      step_o      = (state_q == RUN);
      finish_o    = (state_q == RUN) && last_step;
      in_ready_o  = (state_q == IDLE);
      out_valid_o = (state_q == DONE);
      busy_o      = (state_q != IDLE);
   end

   assign state_o = state_q;
   assign cnt_o   = cnt_q;

endmodule

// File: rtl/seq_shiftadd_mult.sv
// Sequential shift-add multiplier, unsigned or two's-complement, one bit per cycle.
// Optional SEQ_MULT_EARLY_EXIT_EN (in seq_mult_ctrl) shortens RUN for small multipliers.
module seq_shiftadd_mult
   import seq_mult_pkg::*;
#(
   parameter int W = SEQ_MULT_W_DEFAULT
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [W-1:0]   a_in,
   input  logic [W-1:0]   b_in,
   input  logic           is_signed,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*W-1:0] product,
   output logic           busy
);

   localparam int PW = 2 * W;
   localparam int CW = $clog2(W+1);

   state_e          state;
   logic [CW-1:0]   cnt;
   logic            load, step, finish;

   logic [PW-1:0]   mcand_q, mcand_d;
   logic [W-1:0]    mplier_q, mplier_d;
   logic [PW-1:0]   acc_q, acc_d;
   logic            neg_q, neg_d;
   logic [PW-1:0]   product_q, product_d;

   logic [W-1:0]    a_mag, b_mag;
   logic [PW-1:0]   acc_sum;
   logic            mplier_zero;

   seq_mult_ctrl #(.W(W)) u_ctrl (
      .clk           (clk),
      .reset         (reset),
      .in_valid_i    (in_valid),
      .out_ready_i   (out_ready),
      .mplier_zero_i (mplier_zero),
      .state_o       (state),
      .cnt_o         (cnt),
      .load_o        (load),
      .step_o        (step),
      .finish_o      (finish),
      .in_ready_o    (in_ready),
      .out_valid_o   (out_valid),
      .busy_o        (busy)
   );

   // Negating -2^(W-1) wraps back to itself, which read unsigned is exactly 2^(W-1)
   assign a_mag = (is_signed && a_in[W-1]) ? -a_in : a_in;
   assign b_mag = (is_signed && b_in[W-1]) ? -b_in : b_in;

   assign acc_sum     = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
   assign mplier_zero = (mplier_q[W-1:1] == '0);

   always_comb begin
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      acc_d     = acc_q;
      neg_d     = neg_q;
      product_d = product_q;
      if (load) begin
         mcand_d  = {{W{1'b0}}, a_mag};
         mplier_d = b_mag;
         acc_d    = '0;
         neg_d    = is_signed & (a_in[W-1] ^ b_in[W-1]);
      end
      if (step) begin
         acc_d    = acc_sum;
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
      end
      // Negating a zero magnitude gives zero, so no -0 can appear
      if (finish) begin
         product_d = neg_q ? -acc_sum : acc_sum;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mcand_q   <= '0;
         mplier_q  <= '0;
         acc_q     <= '0;
         neg_q     <= 1'b0;
         product_q <= '0;
      end else begin
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         acc_q     <= acc_d;
         neg_q     <= neg_d;
         product_q <= product_d;
      end
   end

   assign product = product_q;

   logic unused_ctrl;
   assign unused_ctrl = ^{state, cnt};

endmodule
